// File: rtl/i2c_sb_pkg.sv
// Shared types and constants for the I2C FIFO system-bus sequencer.
package i2c_sb_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_RCMD,
    S_RPOLL,
    S_RHOLD,
    S_RWAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  // TX FIFO word flags occupying bits [9:8]
  localparam logic [1:0] FLG_DATA  = 2'b00;
  localparam logic [1:0] FLG_START = 2'b01;
  localparam logic [1:0] FLG_STOP  = 2'b10;
  localparam logic [1:0] FLG_RCMD  = 2'b11;

  // Default register map and timeout limits
  localparam logic [3:0] ADR_TXFIFO_DEF = 4'h0;
  localparam logic [3:0] ADR_RXFIFO_DEF = 4'h1;
  localparam int         ACK_TMO_DEF    = 64;
  localparam int         XFER_TMO_DEF   = 65535;

  // Assemble a TX FIFO word from its flag and byte
  function automatic logic [9:0] tx_word(input logic [1:0] flg, input logic [7:0] b);
    return {flg, b};
  endfunction

endpackage

// File: rtl/i2c_sb_access.sv
// Single system-bus access engine: holds cs/stb with stable we/adr/dat until
// the first ack, captures read data in the ack cycle, and gives up after
// ACK_TMO cycles without an ack.
module i2c_sb_access
  import i2c_sb_pkg::*;
#(
  parameter int ACK_TMO = ACK_TMO_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       we,
  input  logic [3:0] adr,
  input  logic [9:0] dat,
  output logic       acc_done,
  output logic       acc_tmo,
  output logic [7:0] rdata,
  output logic       sb_cs,
  output logic       sb_stb,
  output logic       sb_we,
  output logic [3:0] sb_adr,
  output logic [9:0] sb_dat_o,
  input  logic [9:0] sb_dat_i,
  input  logic       sb_ack
);

  localparam int CW = $clog2(ACK_TMO + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TMO - 1);

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tmo_q, tmo_d;
  logic          we_q, we_d;
  logic [3:0]    adr_q, adr_d;
  logic [9:0]    dat_q, dat_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          unused_dat_hi;

  assign unused_dat_hi = ^sb_dat_i[9:8];

  // Next-state logic: accept a new access when idle, finish on ack or timeout
  always_comb begin
    busy_d  = busy_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    if (abort) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      if (sb_ack) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        rdata_d = sb_dat_i[7:0];
      end else if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        tmo_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      we_d   = we;
      adr_d  = adr;
      dat_d  = dat;
    end
  end

  // Access registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc_done = done_q;
  assign acc_tmo  = tmo_q;
  assign rdata    = rdata_q;
  assign sb_cs    = busy_q;
  assign sb_stb   = busy_q;
  assign sb_we    = busy_q & we_q;
  assign sb_adr   = busy_q ? adr_q : 4'h0;
  assign sb_dat_o = busy_q ? dat_q : 10'h000;

endmodule

// File: rtl/i2c_fifo_sb_seq.sv
// Byte-level I2C request sequencer driving the I2C FIFO core system bus:
// builds TX FIFO words for a request, drains the RX FIFO on reads and
// reports completion or timeout.
module i2c_fifo_sb_seq
  import i2c_sb_pkg::*;
#(
  parameter logic [3:0] ADR_TXFIFO = ADR_TXFIFO_DEF,
  parameter logic [3:0] ADR_RXFIFO = ADR_RXFIFO_DEF,
  parameter int         ACK_TMO    = ACK_TMO_DEF,
  parameter int         XFER_TMO   = XFER_TMO_DEF
) (
  input  logic       CLKI,
  input  logic       RSTN,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic       req_rnw,
  input  logic [3:0] req_len,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       err,
  output logic       sb_cs,
  output logic       sb_stb,
  output logic       sb_we,
  output logic [3:0] sb_adr,
  output logic [9:0] sb_dat_o,
  input  logic [9:0] sb_dat_i,
  input  logic       sb_ack,
  input  logic       txfifo_full,
  input  logic       rxfifo_empty,
  input  logic       mrdcmpl,
  output logic       fifo_rst
);

  localparam int XW = $clog2(XFER_TMO + 1);
  localparam logic [XW-1:0] XFER_LAST = XW'(XFER_TMO - 1);

  state_t        state_q, state_d;
  logic [6:0]    addr_q, addr_d;
  logic          rnw_q, rnw_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          issued_q, issued_d;
  logic          last_q, last_d;
  logic [XW-1:0] xfer_q, xfer_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          fifo_rst_q, fifo_rst_d;

  logic       acc_start, acc_abort, acc_we;
  logic [3:0] acc_adr;
  logic [9:0] acc_dat;
  logic       acc_done, acc_tmo;
  logic [7:0] acc_rdata;
  logic       active, xfer_exp;

  i2c_sb_access #(.ACK_TMO(ACK_TMO)) u_access (
    .clk      (CLKI),
    .rst_n    (RSTN),
    .start    (acc_start),
    .abort    (acc_abort),
    .we       (acc_we),
    .adr      (acc_adr),
    .dat      (acc_dat),
    .acc_done (acc_done),
    .acc_tmo  (acc_tmo),
    .rdata    (acc_rdata),
    .sb_cs    (sb_cs),
    .sb_stb   (sb_stb),
    .sb_we    (sb_we),
    .sb_adr   (sb_adr),
    .sb_dat_o (sb_dat_o),
    .sb_dat_i (sb_dat_i),
    .sb_ack   (sb_ack)
  );

  assign active   = (state_q != S_IDLE) && (state_q != S_DONE) &&
                    (state_q != S_ERR1) && (state_q != S_ERR2);
  assign xfer_exp = active && (xfer_q == XFER_LAST);

  // Sequencer next-state, access issue and handshake logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rnw_d     = rnw_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    issued_d  = issued_q;
    last_d    = last_q;
    xfer_d    = active ? xfer_q + 1'b1 : xfer_q;
    rd_data_d = rd_data_q;
    acc_start = 1'b0;
    acc_abort = 1'b0;
    acc_we    = 1'b1;
    acc_adr   = ADR_TXFIFO;
    acc_dat   = 10'h000;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          rnw_d    = req_rnw;
          len_d    = req_len;
          cnt_d    = 4'h0;
          xfer_d   = '0;
          issued_d = 1'b0;
          last_d   = 1'b0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        acc_dat = tx_word(FLG_START, {addr_q, rnw_q});
        if (!issued_q && !txfifo_full) begin
          acc_start = 1'b1;
          issued_d  = 1'b1;
        end
        if (acc_done) begin
          issued_d = 1'b0;
          state_d  = rnw_q ? S_RCMD : S_WDATA;
        end
      end
      S_WDATA: begin
        wr_ready = !issued_q && !txfifo_full;
        acc_dat  = tx_word((cnt_q == len_q) ? FLG_STOP : FLG_DATA, wr_data);
        if (wr_valid && wr_ready) begin
          acc_start = 1'b1;
          issued_d  = 1'b1;
          last_d    = (cnt_q == len_q);
          cnt_d     = cnt_q + 1'b1;
        end
        if (acc_done) begin
          issued_d = 1'b0;
          if (last_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_RCMD: begin
        acc_dat = tx_word(FLG_RCMD, {4'h0, len_q});
        if (!issued_q && !txfifo_full) begin
          acc_start = 1'b1;
          issued_d  = 1'b1;
        end
        if (acc_done) begin
          issued_d = 1'b0;
          state_d  = S_RPOLL;
        end
      end
      S_RPOLL: begin
        acc_we  = 1'b0;
        acc_adr = ADR_RXFIFO;
        if (!issued_q && !rxfifo_empty) begin
          acc_start = 1'b1;
          issued_d  = 1'b1;
        end
        if (acc_done) begin
          issued_d  = 1'b0;
          rd_data_d = acc_rdata;
          state_d   = S_RHOLD;
        end
      end
      S_RHOLD: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          if (cnt_q == len_q) begin
            state_d = S_RWAIT;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_RPOLL;
          end
        end
      end
      S_RWAIT: begin
        if (mrdcmpl) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A timeout overrides whatever the state wanted to do this cycle
    if (active && (acc_tmo || xfer_exp)) begin
      state_d   = S_ERR1;
      acc_abort = xfer_exp;
      acc_start = 1'b0;
      issued_d  = 1'b0;
      wr_ready  = 1'b0;
      rd_valid  = 1'b0;
    end

    fifo_rst_d = (state_d == S_ERR1) || (state_d == S_ERR2);
    done_d     = (state_d == S_DONE) || (state_d == S_ERR2);
    err_d      = (state_d == S_ERR2);
  end

  // Sequencer state and registered status outputs
  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rnw_q      <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      issued_q   <= 1'b0;
      last_q     <= 1'b0;
      xfer_q     <= '0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      fifo_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rnw_q      <= rnw_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      issued_q   <= issued_d;
      last_q     <= last_d;
      xfer_q     <= xfer_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      fifo_rst_q <= fifo_rst_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign fifo_rst  = fifo_rst_q;

endmodule

// File: tb/tb_i2c_fifo_sb_seq.sv
// Self-checking bench for i2c_fifo_sb_seq with a behavioural I2C FIFO core model.
module tb_i2c_fifo_sb_seq;

   logic       CLKI = 1'b0;
   logic       RSTN = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [6:0] req_addr = '0;
   logic       req_rnw = 1'b0;
   logic [3:0] req_len = '0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] wr_data = '0;
   logic       rd_valid;
   logic       rd_ready = 1'b0;
   logic [7:0] rd_data;
   logic       done, err;
   logic       sb_cs, sb_stb, sb_we;
   logic [3:0] sb_adr;
   logic [9:0] sb_dat_o;
   logic [9:0] sb_dat_i = '0;
   logic       sb_ack = 1'b0;
   logic       txfifo_full = 1'b0;
   logic       rxfifo_empty = 1'b1;
   logic       mrdcmpl = 1'b0;
   logic       fifo_rst;

   int nChecks = 0;
   int nFail = 0;

   logic [9:0] txLog[$];
   logic [9:0] expTx[$];
   logic [7:0] rxQ[$];
   logic [7:0] rxSrc[$];
   logic [7:0] wq[$];
   logic [7:0] rdGot[$];

   int ackDelay = 0;
   bit ackEn = 1'b1;
   bit autoFill = 1'b1;
   int ackWait = 0;
   int rxReads = 0;
   int doneSeen, errSeen;
   bit xactTmo;
   int rdUnstable, holdExtraReads;
   int fullIdx = -1;
   int fullViol;
   int rdGap0 = 0;
   int rdGap = 0;

   i2c_fifo_sb_seq dut (
      .CLKI(CLKI), .RSTN(RSTN),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_rnw(req_rnw), .req_len(req_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .done(done), .err(err),
      .sb_cs(sb_cs), .sb_stb(sb_stb), .sb_we(sb_we), .sb_adr(sb_adr),
      .sb_dat_o(sb_dat_o), .sb_dat_i(sb_dat_i), .sb_ack(sb_ack),
      .txfifo_full(txfifo_full), .rxfifo_empty(rxfifo_empty),
      .mrdcmpl(mrdcmpl), .fifo_rst(fifo_rst)
   );

   // Free-running system clock
   initial forever #5 CLKI = ~CLKI;

   // Overall time limit so the run can never hang
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "[TB] watchdog");
   end

   // I2C FIFO core model: acks bus accesses after ackDelay cycles, logs TX
   // words, serves RX bytes and raises mrdcmpl once a read command arrives
   initial forever begin
      @(posedge CLKI);
      #1;
      if (!RSTN) begin
         sb_ack = 1'b0;
         ackWait = 0;
      end else if (sb_ack) begin
         nChecks++;
         if (sb_cs !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL cs_after_ack: sb_cs got %b expected 0", sb_cs);
         end
         sb_ack = 1'b0;
         ackWait = 0;
      end else if (sb_cs && sb_stb && ackEn) begin
         if (ackWait >= ackDelay) begin
            sb_ack = 1'b1;
            if (sb_we && sb_adr == 4'h0) begin
               txLog.push_back(sb_dat_o);
               if (sb_dat_o[9:8] == 2'b11 && autoFill) begin
                  foreach (rxSrc[i]) rxQ.push_back(rxSrc[i]);
                  mrdcmpl = 1'b1;
               end
            end else if (!sb_we && sb_adr == 4'h1) begin
               rxReads++;
               if (rxQ.size() > 0) sb_dat_i = {2'b00, rxQ.pop_front()};
               else sb_dat_i = 10'h3FF;
            end
         end else begin
            ackWait++;
         end
      end else if (!sb_cs) begin
         ackWait = 0;
      end
      if (fifo_rst) rxQ.delete();
      rxfifo_empty = (rxQ.size() == 0);
   end

   // Expected TX word list from the request and the write bytes in wq
   task automatic modelTx(input logic [6:0] a, input logic rnw, input logic [3:0] len);
      expTx.delete();
      expTx.push_back({2'b01, a, rnw});
      if (!rnw) begin
         for (int i = 0; i <= int'(len); i++)
            expTx.push_back({(i == int'(len)) ? 2'b10 : 2'b00, wq[i]});
      end else begin
         expTx.push_back({2'b11, 4'h0, len});
      end
   endtask

   // Drive the write bytes in wq through the wr handshake
   task automatic feedWrites(input int len);
      for (int i = 0; i <= len; i++) begin
         if (i == fullIdx) begin
            wr_valid = 1'b0;
            for (int k = 0; k < 2000 && !wr_ready; k++) @(negedge CLKI);
            txfifo_full = 1'b1;
            wr_valid = 1'b1;
            wr_data = wq[i];
            repeat (10) begin
               @(negedge CLKI);
               if (sb_cs || sb_stb || wr_ready) fullViol++;
            end
            txfifo_full = 1'b0;
            #1;
         end
         wr_valid = 1'b1;
         wr_data = wq[i];
         for (int k = 0; k < 2000 && !wr_ready; k++) @(negedge CLKI);
         @(negedge CLKI);
      end
      wr_valid = 1'b0;
   endtask

   // Collect read bytes, optionally stalling rd_ready and watching stability
   task automatic consumeReads(input int len);
      logic [7:0] cap;
      int r0, g;
      for (int i = 0; i <= len; i++) begin
         for (int k = 0; k < 3000 && !rd_valid; k++) @(negedge CLKI);
         if (!rd_valid) break;
         cap = rd_data;
         r0 = rxReads;
         g = (i == 0) ? rdGap0 : rdGap;
         repeat (g) begin
            @(negedge CLKI);
            if (!rd_valid || rd_data !== cap) rdUnstable++;
         end
         if (i == 0) holdExtraReads = rxReads - r0;
         rd_ready = 1'b1;
         rdGot.push_back(rd_data);
         @(negedge CLKI);
         rd_ready = 1'b0;
      end
   endtask

   // Wait for the done pulse within a cycle budget
   task automatic watchDone();
      for (int k = 0; k < 4000; k++) begin
         @(negedge CLKI);
         if (done) begin
            doneSeen++;
            if (err) errSeen++;
            break;
         end
      end
      if (doneSeen == 0) xactTmo = 1'b1;
   endtask

   // Issue one request and run it to completion
   task automatic applyStimulus(input logic [6:0] a, input logic rnw, input logic [3:0] len);
      txLog.delete();
      rdGot.delete();
      rxQ.delete();
      mrdcmpl = 1'b0;
      doneSeen = 0;
      errSeen = 0;
      xactTmo = 1'b0;
      rdUnstable = 0;
      holdExtraReads = 0;
      fullViol = 0;
      @(negedge CLKI);
      req_valid = 1'b1;
      req_addr = a;
      req_rnw = rnw;
      req_len = len;
      for (int k = 0; k < 50 && !req_ready; k++) @(negedge CLKI);
      @(negedge CLKI);
      req_valid = 1'b0;
      fork
         begin if (!rnw) feedWrites(int'(len)); end
         begin if (rnw) consumeReads(int'(len)); end
         watchDone();
      join
   endtask

   task automatic test_reset();
      logic [8:0] obs;
      RSTN = 1'b0;
      repeat (3) @(negedge CLKI);
      obs = {req_ready, wr_ready, rd_valid, done, err, sb_cs, sb_stb, sb_we, fifo_rst};
      nChecks++;
      if (obs !== 9'b1_0000_0000) begin
         nFail++;
         $display("[TB] FAIL reset_outputs: got %b expected 100000000", obs);
      end
      nChecks++;
      if ({sb_adr, sb_dat_o, rd_data} !== 22'h0) begin
         nFail++;
         $display("[TB] FAIL reset_buses: got %h expected 0", {sb_adr, sb_dat_o, rd_data});
      end
      RSTN = 1'b1;
      repeat (2) @(negedge CLKI);
      nChecks++;
      if (req_ready !== 1'b1 || sb_cs !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL idle_after_reset: req_ready/cs got %b%b expected 10", req_ready, sb_cs);
      end
   endtask

   task automatic test_write();
      wq = '{8'hA5, 8'h3C, 8'hFF};
      ackDelay = 2;
      modelTx(7'h50, 1'b0, 4'd2);
      applyStimulus(7'h50, 1'b0, 4'd2);
      nChecks++;
      if (txLog.size() != expTx.size()) begin
         nFail++;
         $display("[TB] FAIL write_count: got %0d words expected %0d", txLog.size(), expTx.size());
      end
      for (int i = 0; i < expTx.size() && i < txLog.size(); i++) begin
         nChecks++;
         if (txLog[i] !== expTx[i]) begin
            nFail++;
            $display("[TB] FAIL write_word%0d: got %h expected %h", i, txLog[i], expTx[i]);
         end
      end
      nChecks++;
      if (doneSeen != 1 || errSeen != 0) begin
         nFail++;
         $display("[TB] FAIL write_done: got done=%0d err=%0d expected done=1 err=0", doneSeen, errSeen);
      end
      @(negedge CLKI);
      nChecks++;
      if (done !== 1'b0 || req_ready !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL write_after_done: done/req_ready got %b%b expected 01", done, req_ready);
      end
   endtask

   task automatic test_read();
      rxSrc = '{8'h11, 8'h22};
      ackDelay = 1;
      rdGap0 = 0;
      rdGap = 0;
      modelTx(7'h21, 1'b1, 4'd1);
      applyStimulus(7'h21, 1'b1, 4'd1);
      nChecks++;
      if (txLog.size() != 2 || txLog[0] !== expTx[0] || txLog[1] !== expTx[1]) begin
         nFail++;
         $display("[TB] FAIL read_words: got %0d words first %h expected 2 words %h %h",
                  txLog.size(), (txLog.size() > 0) ? txLog[0] : 10'h0, expTx[0], expTx[1]);
      end
      nChecks++;
      if (rdGot.size() != 2 || rdGot[0] !== 8'h11 || rdGot[1] !== 8'h22) begin
         nFail++;
         $display("[TB] FAIL read_data: got %0d bytes first %h expected 11 22",
                  rdGot.size(), (rdGot.size() > 0) ? rdGot[0] : 8'h0);
      end
      nChecks++;
      if (doneSeen != 1 || errSeen != 0) begin
         nFail++;
         $display("[TB] FAIL read_done: got done=%0d err=%0d expected done=1 err=0", doneSeen, errSeen);
      end
   endtask

   task automatic test_txfull();
      wq = '{8'h01, 8'h02, 8'h03, 8'h04};
      ackDelay = 0;
      fullIdx = 2;
      modelTx(7'h3A, 1'b0, 4'd3);
      applyStimulus(7'h3A, 1'b0, 4'd3);
      fullIdx = -1;
      nChecks++;
      if (fullViol != 0) begin
         nFail++;
         $display("[TB] FAIL txfull_window: got %0d busy cycles expected 0", fullViol);
      end
      nChecks++;
      if (txLog.size() != expTx.size()) begin
         nFail++;
         $display("[TB] FAIL txfull_count: got %0d words expected %0d", txLog.size(), expTx.size());
      end
      for (int i = 0; i < expTx.size() && i < txLog.size(); i++) begin
         nChecks++;
         if (txLog[i] !== expTx[i]) begin
            nFail++;
            $display("[TB] FAIL txfull_word%0d: got %h expected %h", i, txLog[i], expTx[i]);
         end
      end
      nChecks++;
      if (doneSeen != 1 || errSeen != 0) begin
         nFail++;
         $display("[TB] FAIL txfull_done: got done=%0d err=%0d expected 1 0", doneSeen, errSeen);
      end
   endtask

   task automatic test_ack_timeout();
      int csHi, rstCnt, rstFirst, rstLast, doneCyc, errCyc, rrAfter;
      csHi = 0; rstCnt = 0; rstFirst = -1; rstLast = -1;
      doneCyc = -1; errCyc = -1; rrAfter = -1;
      ackEn = 1'b0;
      txLog.delete();
      @(negedge CLKI);
      req_valid = 1'b1;
      req_addr = 7'h15;
      req_rnw = 1'b0;
      req_len = 4'd0;
      @(negedge CLKI);
      req_valid = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge CLKI);
         if (sb_cs) csHi++;
         if (fifo_rst) begin
            rstCnt++;
            if (rstFirst < 0) rstFirst = c;
            rstLast = c;
         end
         if (doneCyc >= 0 && c == doneCyc + 1) begin
            rrAfter = int'(req_ready);
            break;
         end
         if (done) begin
            doneCyc = c;
            if (err) errCyc = c;
         end
      end
      ackEn = 1'b1;
      nChecks++;
      if (csHi != 64) begin
         nFail++;
         $display("[TB] FAIL ack_tmo_cs_cycles: got %0d expected 64", csHi);
      end
      nChecks++;
      if (rstCnt != 2 || rstLast - rstFirst != 1) begin
         nFail++;
         $display("[TB] FAIL ack_tmo_fifo_rst: got %0d cycles expected 2 consecutive", rstCnt);
      end
      nChecks++;
      if (doneCyc < 0 || errCyc != doneCyc) begin
         nFail++;
         $display("[TB] FAIL ack_tmo_done_err: got done@%0d err@%0d expected same cycle", doneCyc, errCyc);
      end
      nChecks++;
      if (rrAfter != 1) begin
         nFail++;
         $display("[TB] FAIL ack_tmo_req_ready: got %0d expected 1", rrAfter);
      end
      nChecks++;
      if (txLog.size() != 0) begin
         nFail++;
         $display("[TB] FAIL ack_tmo_words: got %0d expected 0", txLog.size());
      end
   endtask

   task automatic test_rd_backpressure();
      rxSrc = '{8'hC3, 8'h5E};
      ackDelay = 1;
      rdGap0 = 20;
      rdGap = 0;
      applyStimulus(7'h44, 1'b1, 4'd1);
      rdGap0 = 0;
      nChecks++;
      if (holdExtraReads != 0) begin
         nFail++;
         $display("[TB] FAIL bp_extra_reads: got %0d expected 0", holdExtraReads);
      end
      nChecks++;
      if (rdUnstable != 0) begin
         nFail++;
         $display("[TB] FAIL bp_stable: got %0d unstable cycles expected 0", rdUnstable);
      end
      nChecks++;
      if (rdGot.size() != 2 || rdGot[0] !== 8'hC3 || rdGot[1] !== 8'h5E || doneSeen != 1) begin
         nFail++;
         $display("[TB] FAIL bp_data: got %0d bytes done=%0d expected c3 5e done=1", rdGot.size(), doneSeen);
      end
   endtask

   task automatic test_random();
      logic [6:0] a;
      logic rnw;
      logic [3:0] len;
      for (int it = 0; it < 10; it++) begin
         a = 7'($urandom);
         rnw = (it == 4) ? 1'b1 : (it == 3) ? 1'b0 : 1'($urandom);
         len = (it == 3 || it == 4) ? 4'd15 : 4'($urandom);
         ackDelay = $urandom_range(0, 3);
         rdGap0 = $urandom_range(0, 3);
         rdGap = $urandom_range(0, 2);
         wq.delete();
         rxSrc.delete();
         for (int i = 0; i <= int'(len); i++) begin
            wq.push_back(8'($urandom));
            rxSrc.push_back(8'($urandom));
         end
         modelTx(a, rnw, len);
         applyStimulus(a, rnw, len);
         nChecks++;
         if (txLog.size() != expTx.size()) begin
            nFail++;
            $display("[TB] FAIL rand%0d_count: got %0d words expected %0d", it, txLog.size(), expTx.size());
         end
         for (int i = 0; i < expTx.size() && i < txLog.size(); i++) begin
            nChecks++;
            if (txLog[i] !== expTx[i]) begin
               nFail++;
               $display("[TB] FAIL rand%0d_word%0d: got %h expected %h", it, i, txLog[i], expTx[i]);
            end
         end
         if (rnw) begin
            nChecks++;
            if (rdGot.size() != rxSrc.size()) begin
               nFail++;
               $display("[TB] FAIL rand%0d_rdcount: got %0d expected %0d", it, rdGot.size(), rxSrc.size());
            end
            for (int i = 0; i < rxSrc.size() && i < rdGot.size(); i++) begin
               nChecks++;
               if (rdGot[i] !== rxSrc[i]) begin
                  nFail++;
                  $display("[TB] FAIL rand%0d_rd%0d: got %h expected %h", it, i, rdGot[i], rxSrc[i]);
               end
            end
         end
         nChecks++;
         if (doneSeen != 1 || errSeen != 0 || xactTmo) begin
            nFail++;
            $display("[TB] FAIL rand%0d_done: got done=%0d err=%0d expected 1 0", it, doneSeen, errSeen);
         end
      end
   endtask

   task automatic test_reset_midread();
      logic [8:0] obs;
      int doneCnt;
      doneCnt = 0;
      autoFill = 1'b0;
      ackDelay = 0;
      txLog.delete();
      rxQ.delete();
      @(negedge CLKI);
      req_valid = 1'b1;
      req_addr = 7'h2B;
      req_rnw = 1'b1;
      req_len = 4'd0;
      @(negedge CLKI);
      req_valid = 1'b0;
      for (int k = 0; k < 200 && txLog.size() < 2; k++) @(negedge CLKI);
      repeat (3) @(negedge CLKI);
      #2;
      RSTN = 1'b0;
      #1;
      obs = {req_ready, wr_ready, rd_valid, done, err, sb_cs, sb_stb, sb_we, fifo_rst};
      nChecks++;
      if (obs !== 9'b1_0000_0000) begin
         nFail++;
         $display("[TB] FAIL midread_reset: got %b expected 100000000", obs);
      end
      repeat (2) @(negedge CLKI);
      RSTN = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLKI);
         if (done) doneCnt++;
      end
      autoFill = 1'b1;
      nChecks++;
      if (doneCnt != 0 || req_ready !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL midread_no_done: got done=%0d req_ready=%b expected 0 1", doneCnt, req_ready);
      end
   endtask

   // Scenario sequence and summary
   initial begin
      test_reset();
      test_write();
      test_read();
      test_txfull();
      test_ack_timeout();
      test_rd_backpressure();
      test_random();
      test_reset_midread();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
